// File: rtl/cpu_pkg.sv
// Shared encodings for the flag/branch unit: jump opcodes, flag bit indices, FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a; consumers apply their own stall handling.
package cpu_pkg;

   // Jump opcode encodings carried on jmp_op; 5-7 are reserved and behave as none.
   localparam logic [2:0] JOP_NONE = 3'd0;
   localparam logic [2:0] JOP_JZ   = 3'd1;
   localparam logic [2:0] JOP_JN   = 3'd2;
   localparam logic [2:0] JOP_JC   = 3'd3;
   localparam logic [2:0] JOP_JMP  = 3'd4;

   // Bit positions inside the 3-bit condition code register.
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;

   // Branch FSM: IDLE accepts jumps, FL1/FL2 squash the two younger stages.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FL1  = 2'd1,
      ST_FL2  = 2'd2
   } br_state_e;

   // One-hot mask of the flag a conditional jump tests; JMP and none test nothing.
   function automatic logic [2:0] tested_flag_mask(input logic [2:0] op);
      logic [2:0] mask;
      mask = 3'b000;
      case (op)
         JOP_JZ:  mask[FLAG_Z] = 1'b1;
         JOP_JN:  mask[FLAG_N] = 1'b1;
         JOP_JC:  mask[FLAG_C] = 1'b1;
         default: mask = 3'b000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode: maps a jump opcode and the effective flags to taken.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the parent gates the result with its stall and FSM state.
module branch_cond
   import cpu_pkg::*;
(
   input  logic [2:0] jmp_op,
   input  logic [2:0] eff,
   output logic       taken,
   output logic [2:0] clr_mask
);

   // Resolve each opcode against its flag; reserved opcodes fall through as not taken.
   always_comb begin
      taken = 1'b0;
      case (jmp_op)
         JOP_JZ:  taken = eff[FLAG_Z];
         JOP_JN:  taken = eff[FLAG_N];
         JOP_JC:  taken = eff[FLAG_C];
         JOP_JMP: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   // The flag a taken conditional jump consumes; only meaningful when taken is high.
   assign clr_mask = taken ? tested_flag_mask(jmp_op) : 3'b000;

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register plus branch resolution with a two-cycle fetch/decode flush (FLAG_SAVE_EN adds interrupt flag save/restore).
// Latency: branch_taken/branch_target registered, 1 cycle after the jump; flag bypass from ALU is combinational.
// Backpressure: stall freezes every register (flags, FSM, save register, outputs); only rst overrides it.
module flag_branch_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        alu_flag_wr,
   input  logic [2:0]  alu_ccr,
   input  logic        setc,
   input  logic        clrc,
   input  logic [2:0]  jmp_op,
   input  logic [15:0] jmp_target,
   input  logic        int_save,
   input  logic        rti_restore,
   output logic [2:0]  ccr,
   output logic        branch_taken,
   output logic [15:0] branch_target,
   output logic        flush
);

   br_state_e   state_q, state_d;
   logic [2:0]  ccr_q, ccr_d;
   logic        branch_taken_q, branch_taken_d;
   logic [15:0] branch_target_q, branch_target_d;

   logic [2:0]  eff;
   logic [2:0]  eff_ovr;
   logic        cond_taken;
   logic [2:0]  cond_clr_mask;
   logic        take;
   logic        restore_en;
   logic [2:0]  restore_val;

   // Flags the current instruction sees: a same-cycle ALU write bypasses the register.
   assign eff = alu_flag_wr ? alu_ccr : ccr_q;

   branch_cond u_branch_cond (
      .jmp_op   (jmp_op),
      .eff      (eff),
      .taken    (cond_taken),
      .clr_mask (cond_clr_mask)
   );

   // Jumps are only honoured in IDLE; inside the flush window they are squashed instructions.
   assign take = cond_taken && (state_q == ST_IDLE);

   // Effective flags with the explicit carry controls applied; clrc beats setc.
   always_comb begin
      eff_ovr = eff;
      if (setc) eff_ovr[FLAG_C] = 1'b1;
      if (clrc) eff_ovr[FLAG_C] = 1'b0;
   end

`ifdef FLAG_SAVE_EN
   logic [2:0] save_q, save_d;

   // Snapshot the post-override flags on interrupt entry.
   always_comb begin
      save_d = save_q;
      if (!stall && int_save) save_d = eff_ovr;
   end

   // Save register; cleared by reset so a stray restore yields all-zero flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) save_q <= 3'b000;
      else     save_q <= save_d;
   end

   assign restore_en  = rti_restore;
   assign restore_val = save_q;
`else
   logic unused_save_ports;

   // Without the feature the strobes are accepted but have no effect.
   assign unused_save_ports = int_save ^ rti_restore;
   assign restore_en        = 1'b0;
   assign restore_val       = 3'b000;
`endif

   // Next flag value, lowest to highest priority: ALU write, carry controls, jump clear, restore.
   always_comb begin
      ccr_d = eff_ovr;
      if (take)       ccr_d = ccr_d & ~cond_clr_mask;
      if (restore_en) ccr_d = restore_val;
      if (stall)      ccr_d = ccr_q;
   end

   // Flush sequencer and registered branch outputs.
   always_comb begin
      state_d         = state_q;
      branch_taken_d  = 1'b0;
      branch_target_d = branch_target_q;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               state_d         = ST_FL1;
               branch_taken_d  = 1'b1;
               branch_target_d = jmp_target;
            end
         end
         ST_FL1:  state_d = ST_FL2;
         ST_FL2:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (stall) begin
         state_d         = state_q;
         branch_taken_d  = branch_taken_q;
         branch_target_d = branch_target_q;
      end
   end

   // Architectural state; reset is asynchronous so a flush aborts without waiting for clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         ccr_q           <= 3'b000;
         branch_taken_q  <= 1'b0;
         branch_target_q <= 16'h0000;
      end else begin
         state_q         <= state_d;
         ccr_q           <= ccr_d;
         branch_taken_q  <= branch_taken_d;
         branch_target_q <= branch_target_d;
      end
   end

   assign ccr           = ccr_q;
   assign branch_taken  = branch_taken_q;
   assign branch_target = branch_target_q;
   assign flush         = (state_q == ST_FL1) || (state_q == ST_FL2);

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit with hand-computed expectations.
// Latency: outputs checked 1 time unit after each rising edge, or mid-cycle for async reset.
// Backpressure: exercises stall freezing a jump and the flag register.
module tb_flag_branch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        alu_flag_wr = 1'b0;
   logic [2:0]  alu_ccr = 3'b000;
   logic        setc = 1'b0;
   logic        clrc = 1'b0;
   logic [2:0]  jmp_op = 3'd0;
   logic [15:0] jmp_target = 16'h0000;
   logic        int_save = 1'b0;
   logic        rti_restore = 1'b0;
   logic [2:0]  ccr;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        flush;

   int n_checks = 0;
   int n_pass   = 0;

   flag_branch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .alu_flag_wr   (alu_flag_wr),
      .alu_ccr       (alu_ccr),
      .setc          (setc),
      .clrc          (clrc),
      .jmp_op        (jmp_op),
      .jmp_target    (jmp_target),
      .int_save      (int_save),
      .rti_restore   (rti_restore),
      .ccr           (ccr),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .flush         (flush)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 1'b0; alu_flag_wr = 1'b0; alu_ccr = 3'b000; setc = 1'b0; clrc = 1'b0;
      jmp_op = 3'd0; jmp_target = 16'h0000; int_save = 1'b0; rti_restore = 1'b0;
   endtask

   initial begin
      // Reset state, observed without any clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_ccr",    {13'd0, ccr}, 16'd0);
      check("rst_taken",  {15'd0, branch_taken}, 16'd0);
      check("rst_target", branch_target, 16'h0000);
      check("rst_flush",  {15'd0, flush}, 16'd0);
      tick();
      rst = 1'b0;

      // Zero set: JZ taken with bypassed flags, Z cleared, two-cycle flush.
      alu_flag_wr = 1'b1; alu_ccr = 3'b001; jmp_op = 3'd1; jmp_target = 16'h0040;
      tick();
      idle_inputs();
      check("jz_taken",  {15'd0, branch_taken}, 16'd1);
      check("jz_target", branch_target, 16'h0040);
      check("jz_ccr",    {13'd0, ccr}, 16'd0);
      check("jz_fl1",    {15'd0, flush}, 16'd1);
      tick();
      check("jz_pulse_end", {15'd0, branch_taken}, 16'd0);
      check("jz_fl2",    {15'd0, flush}, 16'd1);
      tick();
      check("jz_flush_end", {15'd0, flush}, 16'd0);

      // Load N only, then JZ must not be taken.
      alu_flag_wr = 1'b1; alu_ccr = 3'b010;
      tick();
      idle_inputs();
      check("load_n", {13'd0, ccr}, 16'd2);
      jmp_op = 3'd1; jmp_target = 16'h0099;
      tick();
      idle_inputs();
      check("jz_nt_taken", {15'd0, branch_taken}, 16'd0);
      check("jz_nt_ccr",   {13'd0, ccr}, 16'd2);
      check("jz_nt_flush", {15'd0, flush}, 16'd0);

      // JN taken from the register; then a JMP and a flag write arrive during FL1.
      jmp_op = 3'd2; jmp_target = 16'h1234;
      tick();
      idle_inputs();
      check("jn_taken",  {15'd0, branch_taken}, 16'd1);
      check("jn_target", branch_target, 16'h1234);
      check("jn_ccr",    {13'd0, ccr}, 16'd0);
      jmp_op = 3'd4; jmp_target = 16'h5555; alu_flag_wr = 1'b1; alu_ccr = 3'b110;
      tick();
      idle_inputs();
      check("fl_jmp_no_pulse", {15'd0, branch_taken}, 16'd0);
      check("fl_flag_write",   {13'd0, ccr}, 16'd6);
      check("fl_target_hold",  branch_target, 16'h1234);
      check("fl_fl2",          {15'd0, flush}, 16'd1);
      tick();
      check("fl_end_flush", {15'd0, flush}, 16'd0);
      check("fl_end_taken", {15'd0, branch_taken}, 16'd0);

      // Same-cycle ALU write and JC clear: the clear wins on C only.
      alu_flag_wr = 1'b1; alu_ccr = 3'b111; jmp_op = 3'd3; jmp_target = 16'hBEEF;
      tick();
      idle_inputs();
      check("jc_taken", {15'd0, branch_taken}, 16'd1);
      check("jc_ccr",   {13'd0, ccr}, 16'd3);
      tick();
      tick();
      check("jc_flush_end", {15'd0, flush}, 16'd0);

      // Carry override: ALU writes C=1, setc and clrc both high, clrc wins.
      alu_flag_wr = 1'b1; alu_ccr = 3'b100; setc = 1'b1; clrc = 1'b1;
      tick();
      idle_inputs();
      check("carry_ovr", {13'd0, ccr}, 16'd0);
      setc = 1'b1;
      tick();
      idle_inputs();
      check("setc_only", {13'd0, ccr}, 16'd4);

      // Reserved opcode 7 is treated as none even with all flags set.
      alu_flag_wr = 1'b1; alu_ccr = 3'b111;
      tick();
      idle_inputs();
      jmp_op = 3'd7; jmp_target = 16'h7777;
      tick();
      idle_inputs();
      check("op7_taken", {15'd0, branch_taken}, 16'd0);
      check("op7_flush", {15'd0, flush}, 16'd0);
      check("op7_ccr",   {13'd0, ccr}, 16'd7);

      // Stall: JMP and flag write are both ignored.
      stall = 1'b1; jmp_op = 3'd4; jmp_target = 16'h4444; alu_flag_wr = 1'b1; alu_ccr = 3'b000;
      tick();
      check("stall_taken", {15'd0, branch_taken}, 16'd0);
      check("stall_ccr",   {13'd0, ccr}, 16'd7);
      check("stall_flush", {15'd0, flush}, 16'd0);
      idle_inputs();

      // Save/restore sequence.
      alu_flag_wr = 1'b1; alu_ccr = 3'b101; int_save = 1'b1;
      tick();
      idle_inputs();
      check("save_ccr", {13'd0, ccr}, 16'd5);
      alu_flag_wr = 1'b1; alu_ccr = 3'b010;
      tick();
      idle_inputs();
      check("changed_ccr", {13'd0, ccr}, 16'd2);
      rti_restore = 1'b1;
      tick();
      idle_inputs();
`ifdef FLAG_SAVE_EN
      check("restore_ccr", {13'd0, ccr}, 16'd5);
`else
      check("restore_ignored", {13'd0, ccr}, 16'd2);
`endif

      // Reset mid-FL1 aborts the flush without a clock edge.
      jmp_op = 3'd4; jmp_target = 16'hABCD;
      tick();
      idle_inputs();
      check("pre_rst_flush", {15'd0, flush}, 16'd1);
      #1 rst = 1'b1;
      #1;
      check("async_rst_flush",  {15'd0, flush}, 16'd0);
      check("async_rst_taken",  {15'd0, branch_taken}, 16'd0);
      check("async_rst_target", branch_target, 16'h0000);
      check("async_rst_ccr",    {13'd0, ccr}, 16'd0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_flush", {15'd0, flush}, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
